econet_clkgen: RTL and testbench

- Generates the Econet line clock (mark/space waveform) on input_clk and drives the econet_clkout path of the bidirectional clock pad.
- Watches the pad's returned clock to report whether any Econet clock is present on the network.
- Software uses clk_present to decide whether this station must act as clock master. It then enables this generator and the pad output driver.
- Period and low-time are programmed from the register layer; the generator applies new values glitch-free at cycle boundaries.

---
 rtl/econet_clkgen.sv | 126 ++++++++++++
 tb/tb_econet_clkgen.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/econet_clkgen.sv
// econet_clkgen: Econet line clock generator with clock-presence detector.
//   input_clk     block clock
//   reset         asynchronous active-high reset
//   enable        level, 1 = generate the line clock
//   cfg_wr        strobe, load cfg_period/cfg_low into the pending registers
//   cfg_period    requested period in input_clk cycles
//   cfg_low       requested low (mark) time in input_clk cycles
//   cfg_err       sticky, last cfg_wr was rejected
//   econet_clkout registered generated clock, idles high
//   running       generator is mid-waveform
//   clk_in        asynchronous clock returned from the pad
//   clk_present   an Econet clock (external or looped back) is present
//   clk_lost      one-cycle pulse when clk_present falls
module econet_clkgen #(
  parameter int PERIOD_W       = 10,
  parameter int DEFAULT_PERIOD = 60,
  parameter int DEFAULT_LOW    = 12,
  parameter int LOSS_TIMEOUT   = 240
) (
  input  logic                input_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                cfg_wr,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_low,
  output logic                cfg_err,
  output logic                econet_clkout,
  output logic                running,
  input  logic                clk_in,
  output logic                clk_present,
  output logic                clk_lost
);
  localparam int CNT_W = $clog2(LOSS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(LOSS_TIMEOUT);
  localparam logic [PERIOD_W-1:0] DEF_P = PERIOD_W'(DEFAULT_PERIOD);
  localparam logic [PERIOD_W-1:0] DEF_L = PERIOD_W'(DEFAULT_LOW);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [PERIOD_W-1:0] act_per_q, act_per_d, act_low_q, act_low_d;
  logic [PERIOD_W-1:0] pend_per_q, pend_per_d, pend_low_q, pend_low_d;
  logic pend_v_q, pend_v_d;
  logic err_q, err_d;
  logic clkout_q, clkout_d;
  logic sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic armed_q, armed_d, present_q, present_d, lost_q, lost_d;
  logic terminal, load, cfg_ok, fall, sat;
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  // The decision to keep going is only taken at a waveform boundary, so a
  // waveform in progress always completes whatever enable does meanwhile.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = enable ? RUN : IDLE;
    else state_d = enable ? RUN : (terminal ? IDLE : DRAIN);
  end
  always_comb begin
    running  = state_q != IDLE;
    clkout_d = (state_q == IDLE) ? 1'b1 : (phase_q >= act_low_q);
  end
  always_comb begin
    terminal   = (state_q != IDLE) && (phase_q == act_per_q - PERIOD_W'(1));
    load       = pend_v_q && ((state_q == IDLE) || terminal);
    cfg_ok     = (cfg_period >= PERIOD_W'(2)) && (cfg_low != '0) && (cfg_low < cfg_period);
    phase_d    = ((state_q == IDLE) || terminal) ? '0 : phase_q + PERIOD_W'(1);
    act_per_d  = load ? pend_per_q : act_per_q;
    act_low_d  = load ? pend_low_q : act_low_q;
    pend_per_d = (cfg_wr && cfg_ok) ? cfg_period : pend_per_q;
    pend_low_d = (cfg_wr && cfg_ok) ? cfg_low : pend_low_q;
    pend_v_d   = (cfg_wr && cfg_ok) || (pend_v_q && !load);
    err_d      = cfg_wr ? !cfg_ok : err_q;
    sync1_d    = clk_in;
    sync2_d    = sync1_q;
    edge_d     = sync2_q;
    fall       = edge_q && !sync2_q;
    sat        = cnt_q == TIMEOUT;
    cnt_d      = fall ? '0 : (sat ? cnt_q : cnt_q + CNT_W'(1));
    // armed: a falling edge was seen and the counter has not saturated since,
    // so the next falling edge completes a qualifying pair.
    armed_d    = fall || (armed_q && !sat);
    lost_d     = present_q && sat;
    present_d  = lost_d ? 1'b0 : ((fall && armed_q && !sat) ? 1'b1 : present_q);
  end
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      phase_q    <= '0;
      act_per_q  <= DEF_P;
      act_low_q  <= DEF_L;
      pend_per_q <= DEF_P;
      pend_low_q <= DEF_L;
      pend_v_q   <= 1'b0;
      err_q      <= 1'b0;
      clkout_q   <= 1'b1;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      edge_q     <= 1'b1;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      present_q  <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      act_per_q  <= act_per_d;
      act_low_q  <= act_low_d;
      pend_per_q <= pend_per_d;
      pend_low_q <= pend_low_d;
      pend_v_q   <= pend_v_d;
      err_q      <= err_d;
      clkout_q   <= clkout_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_q     <= edge_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      present_q  <= present_d;
      lost_q     <= lost_d;
    end
  end
  assign cfg_err       = err_q;
  assign econet_clkout = clkout_q;
  assign clk_present   = present_q;
  assign clk_lost      = lost_q;
endmodule

// File: tb/tb_econet_clkgen.sv
// tb_econet_clkgen: scoreboard bench for econet_clkgen against a waveform-level model.
module tb_econet_clkgen;
  localparam int PW = 10;
  logic input_clk = 0, reset = 1, enable = 0, cfg_wr = 0, clk_in = 1;
  logic [PW-1:0] cfg_period = '0, cfg_low = '0;
  logic cfg_err, econet_clkout, running, clk_present, clk_lost;
  int n_vec = 0, n_bad = 0;
  econet_clkgen dut (
    .input_clk(input_clk), .reset(reset), .enable(enable), .cfg_wr(cfg_wr),
    .cfg_period(cfg_period), .cfg_low(cfg_low), .cfg_err(cfg_err),
    .econet_clkout(econet_clkout), .running(running), .clk_in(clk_in),
    .clk_present(clk_present), .clk_lost(clk_lost)
  );
  always #5 input_clk = ~input_clk;
  typedef struct packed {logic ck; logic run; logic err; logic pres; logic lost;} exp_t;
  exp_t exp_q[$];
  task automatic chk(string nm, logic act, logic req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, req, $time);
    end
  endtask
  // Reference model: the output is a stream of whole waveforms. When the
  // stream runs dry with enable high, the next waveform (low zeros, then
  // period-low ones) is appended using the latest accepted config.
  // Presence is judged from timestamps of falling edges as seen through a
  // fixed two-edge synchroniser delay.
  bit wq[$];
  int cur_p, cur_l, pend_p, pend_l, cyc, last_fall;
  bit pend_v, err_m, pres_m, have_last;
  bit hs[4];
  initial forever begin
    @(posedge input_clk);
    if (reset) begin
      wq.delete();
      cur_p = 60; cur_l = 12; pend_p = 60; pend_l = 12; pend_v = 0;
      err_m = 0; pres_m = 0; have_last = 0; cyc = 0;
      for (int i = 0; i < 4; i++) hs[i] = 1;
      exp_q.push_back(exp_t'{ck:1'b1, run:1'b0, err:1'b0, pres:1'b0, lost:1'b0});
    end else begin
      bit ck, lost, fall;
      int p, l;
      cyc++;
      ck = 1;
      if (wq.size() != 0) ck = wq.pop_front();
      if (wq.size() == 0 && enable) begin
        if (pend_v) begin cur_p = pend_p; cur_l = pend_l; pend_v = 0; end
        for (int i = 0; i < cur_p; i++) wq.push_back(i >= cur_l);
      end
      if (cfg_wr) begin
        p = int'(cfg_period); l = int'(cfg_low);
        if (p >= 2 && l >= 1 && l < p) begin
          pend_p = p; pend_l = l; pend_v = 1; err_m = 0;
        end else err_m = 1;
      end
      for (int i = 3; i > 0; i--) hs[i] = hs[i-1];
      hs[0] = clk_in;
      fall = !hs[2] && hs[3];
      lost = 0;
      if (pres_m && have_last && cyc - last_fall == 241) begin pres_m = 0; lost = 1; end
      if (fall) begin
        if (have_last && cyc - last_fall <= 240 && !lost) pres_m = 1;
        last_fall = cyc; have_last = 1;
      end
      exp_q.push_back(exp_t'{ck:ck, run:(wq.size() != 0), err:err_m, pres:pres_m, lost:lost});
    end
  end
  initial forever begin
    exp_t e;
    @(negedge input_clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (reset) e = exp_t'{ck:1'b1, run:1'b0, err:1'b0, pres:1'b0, lost:1'b0};
      chk("econet_clkout", econet_clkout, e.ck);
      chk("running", running, e.run);
      chk("cfg_err", cfg_err, e.err);
      chk("clk_present", clk_present, e.pres);
      chk("clk_lost", clk_lost, e.lost);
    end
  end
  int ck_half = 0, ck_cnt = 0;
  bit ck_lvl = 1, done = 0;
  initial while (!done) begin
    @(posedge input_clk); #2;
    if (ck_half == 0) clk_in = ck_lvl;
    else if (++ck_cnt >= ck_half) begin ck_cnt = 0; clk_in = ~clk_in; end
  end
  task automatic tick(int n = 1);
    repeat (n) begin @(posedge input_clk); #2; cfg_wr = 0; end
  endtask
  task automatic wr(int p, int l);
    cfg_wr = 1; cfg_period = PW'(p); cfg_low = PW'(l);
    tick();
  endtask
  initial begin
    #2;
    tick(3);
    reset = 0;
    tick(9);
    enable = 1;
    tick(150);
    wr(40, 8);
    tick(200);
    wr(10, 10);
    tick(40);
    wr(10, 3);
    tick(60);
    wr(60, 12);
    tick(75);
    enable = 0;
    tick(30);
    enable = 1;
    tick(20);
    enable = 0;
    tick(150);
    ck_half = 30;
    tick(700);
    ck_half = 0; ck_lvl = 1;
    tick(400);
    ck_lvl = 0;
    tick(50);
    ck_lvl = 1;
    tick(400);
    enable = 1;
    for (int i = 0; i < 200 && econet_clkout !== 1'b0; i++) tick();
    chk("wait_low", econet_clkout, 1'b0);
    tick(3);
    reset = 1;
    #1 chk("async_reset_out", econet_clkout, 1'b1);
    tick(2);
    reset = 0;
    tick(150);
    for (int i = 0; i < 7000; i++) begin
      if ($urandom % 60 == 0) begin
        cfg_wr = 1;
        cfg_period = PW'($urandom_range(0, 70));
        cfg_low = PW'($urandom_range(0, 70));
      end
      if ($urandom % 250 == 0) enable = ~enable;
      if ($urandom % 400 == 0) begin
        ck_half = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(5, 150));
        ck_lvl = $urandom_range(0, 1) != 0;
      end
      if ($urandom % 2500 == 0) begin reset = 1; tick(2); reset = 0; end
      tick();
    end
    tick(3);
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
